// File: rtl/fir_neuron_mac_if.sv
// Sample, configuration and result handshake bundle for fir_neuron_mac.
// The master side is the sample source / controller; the slave side is the neuron.
interface fir_neuron_mac_if #(
   parameter int DATA_W = 12,
   parameter int ACC_W  = 24,
   parameter int TAPS   = 36
);

   logic [DATA_W-1:0]       x_in;
   logic                    x_valid;
   logic                    x_ready;
   logic                    w_we;
   logic [$clog2(TAPS)-1:0] w_addr;
   logic [DATA_W-1:0]       w_data;
   logic                    b_we;
   logic [ACC_W-1:0]        b_data;
   logic                    mode;
   logic                    relu_en;
   logic [ACC_W-1:0]        y_out;
   logic                    y_valid;
   logic                    y_ready;
   logic                    busy;

   modport master (
      output x_in, x_valid, w_we, w_addr, w_data, b_we, b_data, mode, relu_en, y_ready,
      input  x_ready, y_out, y_valid, busy
   );

   modport slave (
      input  x_in, x_valid, w_we, w_addr, w_data, b_we, b_data, mode, relu_en, y_ready,
      output x_ready, y_out, y_valid, busy
   );

endinterface

// File: rtl/fir_neuron_mac.sv
// Time-multiplexed FIR neuron: sliding window of TAPS signed samples, one multiplier,
// bias-seeded accumulation, then saturation and optional ReLU on the way out.
module fir_neuron_mac #(
   parameter int DATA_W = 12,
   parameter int FRAC   = 8,
   parameter int ACC_W  = 24,
   parameter int TAPS   = 36
) (
   input logic             clk,
   input logic             reset,
   fir_neuron_mac_if.slave bus
);

   localparam int AW = $clog2(TAPS);
   localparam int CW = $clog2(TAPS + 1);
   localparam int PW = 2 * DATA_W;
   localparam int SW = ACC_W + AW + 1;

   localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
   localparam logic [CW-1:0] FULL = CW'(TAPS);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;
   localparam logic [1:0] ST_OUT  = 2'd3;

   if (ACC_W < 2 * DATA_W || FRAC >= DATA_W || TAPS < 2 || TAPS > 256) begin : g_bad_param
      $error("fir_neuron_mac: illegal parameter combination");
   end

   logic [1:0]               state_q, state_d;
   logic signed [DATA_W-1:0] smp_q [TAPS];
   logic signed [DATA_W-1:0] wgt_q [TAPS];
   logic signed [ACC_W-1:0]  bias_q;
   logic [AW-1:0]            wp_q, wp_d;
   logic [AW-1:0]            rp_q, rp_d;
   logic [AW-1:0]            k_q, k_d;
   logic [CW-1:0]            cnt_q, cnt_d, cnt_inc;
   logic signed [SW-1:0]     acc_q, acc_d;
   logic [ACC_W-1:0]         y_q, y_d;
   logic                     yv_q, yv_d;

   logic                     busy;
   logic                     accept;
   logic                     cfg_ok;
   logic signed [ACC_W-1:0]  bias_eff;
   logic signed [PW-1:0]     prod;
   logic [SW-ACC_W:0]        acc_top;
   logic [ACC_W-1:0]         sat;
   logic [ACC_W-1:0]         res;

   assign busy   = (state_q != ST_IDLE);
   assign accept = (state_q == ST_IDLE) && bus.x_valid;
   assign cfg_ok = !busy;

   // A bias written on the accept edge must seed this very computation.
   assign bias_eff = bus.b_we ? $signed(bus.b_data) : bias_q;

   assign prod    = PW'(wgt_q[k_q]) * PW'(smp_q[rp_q]);
   assign acc_top = acc_q[SW-1:ACC_W-1];

   always_comb begin
      sat = acc_q[ACC_W-1:0];
      if (acc_top != '0 && acc_top != '1) begin
         sat = acc_q[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
      res = (bus.relu_en && sat[ACC_W-1]) ? '0 : sat;
   end

   assign cnt_inc = (cnt_q == FULL) ? FULL : cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      y_d     = y_q;
      yv_d    = yv_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.x_valid) begin
               wp_d  = (wp_q == LAST) ? '0 : wp_q + 1'b1;
               rp_d  = wp_q;
               cnt_d = cnt_inc;
               if (cnt_inc == FULL) begin
                  state_d = ST_MAC;
                  acc_d   = SW'(bias_eff);
                  k_d     = '0;
               end
            end
         end
         ST_MAC: begin
            // Walk from the newest sample backwards while k walks the weights forwards.
            acc_d = acc_q + SW'(prod);
            rp_d  = (rp_q == '0) ? LAST : rp_q - 1'b1;
            k_d   = k_q + 1'b1;
            if (k_q == LAST) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            y_d     = res;
            yv_d    = 1'b1;
            k_d     = '0;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (bus.y_ready) begin
               yv_d    = 1'b0;
               state_d = ST_IDLE;
               if (bus.mode) begin
                  cnt_d = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            smp_q[i] <= '0;
            wgt_q[i] <= '0;
         end
         bias_q  <= '0;
         state_q <= ST_IDLE;
         wp_q    <= '0;
         rp_q    <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         y_q     <= '0;
         yv_q    <= 1'b0;
      end else begin
         if (accept) begin
            smp_q[wp_q] <= $signed(bus.x_in);
         end
         if (cfg_ok && bus.w_we && bus.w_addr <= LAST) begin
            wgt_q[bus.w_addr] <= $signed(bus.w_data);
         end
         if (cfg_ok && bus.b_we) begin
            bias_q <= $signed(bus.b_data);
         end
         state_q <= state_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         y_q     <= y_d;
         yv_q    <= yv_d;
      end
   end

   // Ready is also masked by reset so nothing is offered while reset is held.
   assign bus.x_ready = (state_q == ST_IDLE) && !reset;
   assign bus.y_out   = y_q;
   assign bus.y_valid = yv_q;
   assign bus.busy    = busy;

endmodule
